// File: rtl/spi_slave_driver.sv
// spi_slave_driver: CPOL=0/CPHA=0 SPI slave with synchronized pins, one-entry tx holding register and rx byte output.
module spi_slave_driver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_bi,
  input  logic       tx_load_i,
  output logic       tx_pending_o,
  output logic [7:0] rx_data_bo,
  output logic       rx_valid_o,
  output logic       busy_o,
  input  logic       spi_sclk_i,
  input  logic       spi_mosi_i,
  input  logic       spi_cs_i,
  output logic       spi_miso_o
);
  typedef enum logic {IDLE, ACTIVE} state_e;
  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic sclk_prev_q, cs_prev_q;
  logic [7:0] hold_q, hold_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic pending_q, pending_d, reload_q, reload_d, rx_valid_q, rx_valid_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic sclk_s, mosi_s, cs_s, sclk_rise, sclk_fall, cs_fall, cs_rise, load_sh;
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= IDLE;
      hold_q      <= 8'h00;
      pending_q   <= 1'b0;
      tx_sh_q     <= 8'h00;
      rx_sh_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      bitcnt_q    <= 3'd0;
      reload_q    <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      hold_q      <= hold_d;
      pending_q   <= pending_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      bitcnt_q    <= bitcnt_d;
      reload_q    <= reload_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    pending_d  = pending_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    bitcnt_d   = bitcnt_q;
    reload_d   = reload_q;
    load_sh    = 1'b0;
    if (state_q == IDLE) begin
      if (cs_fall) begin
        state_d  = ACTIVE;
        load_sh  = 1'b1;
        bitcnt_d = 3'd0;
        reload_d = 1'b0;
      end
    end else if (cs_rise) begin
      state_d  = IDLE;
      bitcnt_d = 3'd0;
      reload_d = 1'b0;
    end else begin
      if (sclk_rise) begin
        rx_sh_d  = {rx_sh_q[6:0], mosi_s};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          rx_data_d  = {rx_sh_q[6:0], mosi_s};
          rx_valid_d = 1'b1;
          reload_d   = 1'b1;
        end
      end
      if (sclk_fall) begin
        load_sh  = reload_q;
        reload_d = 1'b0;
        tx_sh_d  = {tx_sh_q[6:0], 1'b0};
      end
    end
    // A shifter load takes the old hold content; a same-cycle tx_load_i lands afterwards
    if (load_sh) begin
      tx_sh_d   = pending_q ? hold_q : 8'h00;
      pending_d = 1'b0;
    end
    if (tx_load_i) begin
      hold_d    = tx_data_bi;
      pending_d = 1'b1;
    end
  end
  assign tx_pending_o = pending_q;
  assign rx_data_bo   = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign busy_o       = ~cs_s;
  assign spi_miso_o   = tx_sh_q[7] & ~cs_s;
endmodule

// File: tb/tb_spi_slave_driver.sv
// tb_spi_slave_driver: directed SPI master transfers checked against a byte-level model of the slave.
module tb_spi_slave_driver;
  localparam int SYNC = 2;
  localparam int H = 6;
  logic clk_i = 1'b0;
  logic rst_i, tx_load_i, spi_sclk_i, spi_mosi_i, spi_cs_i;
  logic [7:0] tx_data_bi, rx_data_bo;
  logic tx_pending_o, rx_valid_o, busy_o, spi_miso_o;
  int n_cmp = 0, n_err = 0;
  logic [7:0] m_hold = 8'h00, cur_tx = 8'h00, mb;
  logic m_pending = 1'b0, prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  spi_slave_driver #(.SYNC_STAGES(SYNC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tx_data_bi(tx_data_bi), .tx_load_i(tx_load_i),
    .tx_pending_o(tx_pending_o), .rx_data_bo(rx_data_bo), .rx_valid_o(rx_valid_o),
    .busy_o(busy_o), .spi_sclk_i(spi_sclk_i), .spi_mosi_i(spi_mosi_i),
    .spi_cs_i(spi_cs_i), .spi_miso_o(spi_miso_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
    tx_load_i = 1'b0;
  endtask
  // Model: hold register consumed at CS fall and at each byte boundary fall
  task automatic consume();
    cur_tx = m_pending ? m_hold : 8'h00;
    m_pending = 1'b0;
  endtask
  task automatic load(input logic [7:0] v);
    tx_data_bi = v;
    tx_load_i = 1'b1;
    m_hold = v;
    m_pending = 1'b1;
  endtask
  task automatic cs_low();
    spi_cs_i = 1'b0;
    consume();
    repeat (H) tick();
  endtask
  task automatic cs_high();
    repeat (H) tick();
    spi_cs_i = 1'b1;
    repeat (2 * H) tick();
    check("rx_pulse_count", exp_q.size(), 0);
  endtask
  task automatic xfer(input logic [7:0] mosi_b, input int nbits, input bit do_load,
                      input logic [7:0] lv, output logic [7:0] miso_b);
    bit loaded;
    miso_b = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi_i = mosi_b[7-i];
      repeat (H) tick();
      miso_b[7-i] = spi_miso_o;
      spi_sclk_i = 1'b1;
      if (i == 7) exp_q.push_back(mosi_b);
      loaded = 1'b0;
      for (int c = 0; c < H; c++) begin
        tick();
        if (i == 7 && do_load && !loaded && rx_valid_o) begin
          load(lv);
          loaded = 1'b1;
        end
      end
      if (i == 7 && do_load) check("load_after_rx_pulse", loaded, 1'b1);
      spi_sclk_i = 1'b0;
      if (i == 7) begin
        check("miso_byte_model", miso_b, cur_tx);
        consume();
      end
    end
  endtask
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (!busy_o) check("miso_idle", spi_miso_o, 1'b0);
      check("rx_valid_width", rx_valid_o & prev_valid, 1'b0);
      if (rx_valid_o) begin
        if (exp_q.size() == 0) check("rx_spurious", rx_valid_o, 1'b0);
        else check("rx_data", rx_data_bo, exp_q.pop_front());
      end
      prev_valid = rx_valid_o;
    end
  end
  initial begin
    rst_i = 1'b0; tx_load_i = 1'b0; tx_data_bi = 8'h00;
    spi_sclk_i = 1'b0; spi_mosi_i = 1'b0; spi_cs_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_miso", spi_miso_o, 1'b0);
    check("rst_rx_data", rx_data_bo, 8'h00);
    check("rst_rx_valid", rx_valid_o, 1'b0);
    check("rst_pending", tx_pending_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    rst_i = 1'b1;
    repeat (4) tick();
    check("post_rst_busy", busy_o, 1'b0);
    // single byte
    load(8'hA5);
    tick();
    tick();
    check("pending_after_load", tx_pending_o, 1'b1);
    cs_low();
    check("busy_active", busy_o, 1'b1);
    check("pending_after_csfall", tx_pending_o, 1'b0);
    xfer(8'h3C, 8, 1'b0, 8'h00, mb);
    check("miso_single", mb, 8'hA5);
    cs_high();
    check("rx_single", rx_data_bo, 8'h3C);
    check("busy_idle", busy_o, 1'b0);
    // two bytes in one CS
    load(8'h81);
    tick();
    cs_low();
    xfer(8'h12, 8, 1'b1, 8'h7E, mb);
    check("miso_two_a", mb, 8'h81);
    xfer(8'h34, 8, 1'b0, 8'h00, mb);
    check("miso_two_b", mb, 8'h7E);
    cs_high();
    check("rx_two", rx_data_bo, 8'h34);
    // underrun
    cs_low();
    xfer(8'hFF, 8, 1'b0, 8'h00, mb);
    check("miso_underrun", mb, 8'h00);
    cs_high();
    check("rx_underrun", rx_data_bo, 8'hFF);
    // abort after 5 bits, then a full byte
    cs_low();
    xfer(8'hA0, 5, 1'b0, 8'h00, mb);
    cs_high();
    check("rx_abort_kept", rx_data_bo, 8'hFF);
    cs_low();
    xfer(8'h55, 8, 1'b0, 8'h00, mb);
    check("miso_after_abort", mb, 8'h00);
    cs_high();
    check("rx_after_abort", rx_data_bo, 8'h55);
    // load collides with the cs_fall strobe
    load(8'h11);
    tick();
    spi_cs_i = 1'b0;
    repeat (SYNC) tick();
    consume();
    load(8'h99);
    repeat (H) tick();
    check("pending_collision", tx_pending_o, 1'b1);
    xfer(8'h5A, 8, 1'b0, 8'h00, mb);
    check("miso_collision_a", mb, 8'h11);
    xfer(8'hA6, 8, 1'b0, 8'h00, mb);
    check("miso_collision_b", mb, 8'h99);
    cs_high();
    check("rx_collision", rx_data_bo, 8'hA6);
    // reset mid-byte
    cs_low();
    load(8'h42);
    tick();
    xfer(8'hC3, 3, 1'b0, 8'h00, mb);
    #2 rst_i = 1'b0;
    #1;
    check("midrst_miso", spi_miso_o, 1'b0);
    check("midrst_rx_data", rx_data_bo, 8'h00);
    check("midrst_rx_valid", rx_valid_o, 1'b0);
    check("midrst_pending", tx_pending_o, 1'b0);
    check("midrst_busy", busy_o, 1'b0);
    spi_cs_i = 1'b1; spi_sclk_i = 1'b0; spi_mosi_i = 1'b0;
    m_pending = 1'b0; m_hold = 8'h00; cur_tx = 8'h00;
    exp_q.delete();
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    repeat (4) tick();
    check("after_rst_busy", busy_o, 1'b0);
    check("after_rst_pending", tx_pending_o, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
